// File: rtl/hazard_control_unit.sv
// Load-use / memory-wait stall controller for the 5-stage pipeline; drives PC, IF/ID, ID/EX and pipe-hold controls.
// Zero-latency combinational outputs from state and inputs; multi-bubble and memory-wait sequencing is held in state.
module hazard_control_unit #(
   parameter int REG_ADDR_W      = 5,
   parameter int LOAD_USE_STALLS = 1,
   parameter int PERF_W          = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  branch_taken_id,
   input  logic                  jump_id,
   input  logic                  mem_read_ex,
   input  logic [REG_ADDR_W-1:0] rt_ex,
   input  logic [REG_ADDR_W-1:0] rs_id,
   input  logic [REG_ADDR_W-1:0] rt_id,
   input  logic                  uses_rs_id,
   input  logic                  uses_rt_id,
   input  logic                  mem_req_mem,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_bubble,
   output logic                  if_id_flush,
   output logic                  pipe_hold,
   output logic [PERF_W-1:0]     stall_cycles
);

   typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

   localparam bit                MULTI_BUBBLE = (LOAD_USE_STALLS > 1);
   localparam logic [3:0]        LU_RELOAD    = 4'(LOAD_USE_STALLS - 1);
   localparam logic [PERF_W-1:0] PERF_ONE     = {{(PERF_W-1){1'b0}}, 1'b1};
   localparam logic [PERF_W-1:0] PERF_MAX     = {PERF_W{1'b1}};

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

   logic hz, mw;
   logic pc_write_c, if_id_write_c, bubble_c, hold_c;

   assign hz = mem_read_ex && (rt_ex != '0) &&
               ((uses_rs_id && (rs_id == rt_ex)) || (uses_rt_id && (rt_id == rt_ex)));
   assign mw = mem_req_mem && !mem_ready;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_write_c    = 1'b1;
      if_id_write_c = 1'b1;
      bubble_c      = 1'b0;
      hold_c        = 1'b0;

      case (state_q)
         RUN: begin
            if (mw) begin
               hold_c  = 1'b1;
               state_d = MEM_WAIT;
            end else if (hz) begin
               bubble_c = 1'b1;
               if (MULTI_BUBBLE) begin
                  state_d = LU_STALL;
                  cnt_d   = LU_RELOAD;
               end
            end
         end
         LU_STALL: begin
            if (mw) begin
               hold_c  = 1'b1;
               state_d = MEM_WAIT;
            end else begin
               bubble_c = 1'b1;
               if (cnt_q <= 4'd1) begin
                  state_d = RUN;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         MEM_WAIT: begin
            if (mw) begin
               hold_c = 1'b1;
            end else if (cnt_q != 4'd0) begin
               // Pending bubbles resume after the release cycle, which itself obeys RUN rules.
               state_d  = LU_STALL;
               bubble_c = hz;
            end else if (hz) begin
               bubble_c = 1'b1;
               state_d  = MULTI_BUBBLE ? LU_STALL : RUN;
               if (MULTI_BUBBLE) begin
                  cnt_d = LU_RELOAD;
               end
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 4'd0;
         end
      endcase

      if (hold_c || bubble_c) begin
         pc_write_c    = 1'b0;
         if_id_write_c = 1'b0;
      end
   end

   assign pc_write     = reset | pc_write_c;
   assign if_id_write  = reset | if_id_write_c;
   assign id_ex_bubble = !reset && bubble_c;
   assign pipe_hold    = !reset && hold_c;
   // Flush only on cycles the PC advances; a held branch stays in ID and is re-evaluated.
   assign if_id_flush  = !reset && pc_write_c && (branch_taken_id || jump_id);
   assign stall_cycles = stall_cycles_q;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (!pc_write_c && (stall_cycles_q != PERF_MAX)) begin
         stall_cycles_d = stall_cycles_q + PERF_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         cnt_q          <= 4'd0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: three instances (1, 2 and 3 bubbles; the last with a 4-bit counter).
module tb_hazard_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       branch_taken_id, jump_id, mem_read_ex;
   logic [4:0] rt_ex, rs_id, rt_id;
   logic       uses_rs_id, uses_rt_id, mem_req_mem, mem_ready;

   logic pw1, iw1, bb1, fl1, ph1;
   logic pw2, iw2, bb2, fl2, ph2;
   logic pw3, iw3, bb3, fl3, ph3;
   logic [15:0] sc1, sc2;
   logic [3:0]  sc3;
   logic [4:0]  ctl1, ctl2, ctl3;

   int n_cmp = 0;
   int n_err = 0;

   assign ctl1 = {pw1, iw1, bb1, fl1, ph1};
   assign ctl2 = {pw2, iw2, bb2, fl2, ph2};
   assign ctl3 = {pw3, iw3, bb3, fl3, ph3};

   always #5 clk = ~clk;

   hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .PERF_W(16)) u1 (
      .clk(clk), .reset(reset), .branch_taken_id(branch_taken_id), .jump_id(jump_id),
      .mem_read_ex(mem_read_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
      .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .mem_req_mem(mem_req_mem),
      .mem_ready(mem_ready), .pc_write(pw1), .if_id_write(iw1), .id_ex_bubble(bb1),
      .if_id_flush(fl1), .pipe_hold(ph1), .stall_cycles(sc1));

   hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(2), .PERF_W(16)) u2 (
      .clk(clk), .reset(reset), .branch_taken_id(branch_taken_id), .jump_id(jump_id),
      .mem_read_ex(mem_read_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
      .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .mem_req_mem(mem_req_mem),
      .mem_ready(mem_ready), .pc_write(pw2), .if_id_write(iw2), .id_ex_bubble(bb2),
      .if_id_flush(fl2), .pipe_hold(ph2), .stall_cycles(sc2));

   hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(3), .PERF_W(4)) u3 (
      .clk(clk), .reset(reset), .branch_taken_id(branch_taken_id), .jump_id(jump_id),
      .mem_read_ex(mem_read_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
      .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .mem_req_mem(mem_req_mem),
      .mem_ready(mem_ready), .pc_write(pw3), .if_id_write(iw3), .id_ex_bubble(bb3),
      .if_id_flush(fl3), .pipe_hold(ph3), .stall_cycles(sc3));

   // Control vectors below are {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold}.

   task automatic set_idle;
      branch_taken_id = 1'b0; jump_id = 1'b0; mem_read_ex = 1'b0;
      rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
      uses_rs_id = 1'b0; uses_rt_id = 1'b0; mem_req_mem = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic set_hz;
      mem_read_ex = 1'b1; rt_ex = 5'd5; rs_id = 5'd5; uses_rs_id = 1'b1;
   endtask

   task automatic do_reset;
      @(negedge clk); set_idle; reset = 1'b1;
      @(negedge clk);
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk); reset = 1'b1; set_hz; branch_taken_id = 1'b1; mem_req_mem = 1'b1;
      #1;
      n_cmp++;
      if (ctl1 !== 5'b11000) begin
         n_err++; $display("FAIL reset_outputs: got %b want 11000", ctl1);
      end
      @(negedge clk); set_idle; reset = 1'b0; #1;
      n_cmp++;
      if (sc1 !== 16'd0 || sc2 !== 16'd0 || sc3 !== 4'd0) begin
         n_err++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", sc1, sc2, sc3);
      end
      n_cmp++;
      if (ctl3 !== 5'b11000) begin
         n_err++; $display("FAIL reset_run_idle: got %b want 11000", ctl3);
      end
   endtask

   task automatic test_load_use_1;
      do_reset;
      @(negedge clk); set_hz; #1;
      n_cmp++;
      if (ctl1 !== 5'b00100) begin
         n_err++; $display("FAIL lu1_bubble: got %b want 00100", ctl1);
      end
      @(negedge clk); set_idle; #1;
      n_cmp++;
      if (ctl1 !== 5'b11000 || sc1 !== 16'd1) begin
         n_err++; $display("FAIL lu1_resume: got %b sc=%0d want 11000 sc=1", ctl1, sc1);
      end
      // Hazard through the rt operand.
      @(negedge clk); mem_read_ex = 1'b1; rt_ex = 5'd9; rt_id = 5'd9; uses_rt_id = 1'b1; #1;
      n_cmp++;
      if (ctl1 !== 5'b00100) begin
         n_err++; $display("FAIL lu1_rt_bubble: got %b want 00100", ctl1);
      end
   endtask

   task automatic test_no_hazard;
      do_reset;
      @(negedge clk); set_idle; mem_read_ex = 1'b1; rt_ex = 5'd0; rs_id = 5'd0; uses_rs_id = 1'b1; #1;
      n_cmp++;
      if (ctl1 !== 5'b11000) begin
         n_err++; $display("FAIL nohz_r0: got %b want 11000", ctl1);
      end
      @(negedge clk); set_idle; mem_read_ex = 1'b1; rt_ex = 5'd5; rs_id = 5'd5; uses_rs_id = 1'b0; #1;
      n_cmp++;
      if (ctl1 !== 5'b11000) begin
         n_err++; $display("FAIL nohz_unused: got %b want 11000", ctl1);
      end
      @(negedge clk); set_idle; #1;
      n_cmp++;
      if (sc1 !== 16'd0) begin
         n_err++; $display("FAIL nohz_count: got %0d want 0", sc1);
      end
   endtask

   task automatic test_load_use_2;
      do_reset;
      @(negedge clk); set_hz; #1;
      n_cmp++;
      if (ctl2 !== 5'b00100) begin
         n_err++; $display("FAIL lu2_c0: got %b want 00100", ctl2);
      end
      @(negedge clk); set_idle; #1;
      n_cmp++;
      if (ctl2 !== 5'b00100) begin
         n_err++; $display("FAIL lu2_c1: got %b want 00100", ctl2);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (ctl2 !== 5'b11000 || sc2 !== 16'd2) begin
         n_err++; $display("FAIL lu2_c2: got %b sc=%0d want 11000 sc=2", ctl2, sc2);
      end
   endtask

   task automatic test_mem_wait_flush;
      do_reset;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); set_idle; mem_req_mem = 1'b1; branch_taken_id = 1'b1; #1;
         n_cmp++;
         if (ctl1 !== 5'b00001) begin
            n_err++; $display("FAIL mw_hold_c%0d: got %b want 00001", c, ctl1);
         end
      end
      @(negedge clk); mem_ready = 1'b1; #1;
      n_cmp++;
      if (ctl1 !== 5'b11010 || sc1 !== 16'd3) begin
         n_err++; $display("FAIL mw_release: got %b sc=%0d want 11010 sc=3", ctl1, sc1);
      end
      @(negedge clk); set_idle; jump_id = 1'b1; #1;
      n_cmp++;
      if (ctl1 !== 5'b11010) begin
         n_err++; $display("FAIL jump_flush: got %b want 11010", ctl1);
      end
   endtask

   task automatic test_lu3_with_mem_wait;
      logic [4:0] exp_ctl [7];
      logic       drv_hz  [7];
      logic       drv_mw  [7];
      exp_ctl = '{5'b00100, 5'b00001, 5'b00001, 5'b11000, 5'b00100, 5'b00100, 5'b11000};
      drv_hz  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      drv_mw  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk); set_idle;
         if (drv_hz[c]) set_hz;
         mem_req_mem = drv_mw[c];
         #1;
         n_cmp++;
         if (ctl3 !== exp_ctl[c]) begin
            n_err++; $display("FAIL lu3mw_c%0d: got %b want %b", c, ctl3, exp_ctl[c]);
         end
      end
      n_cmp++;
      if (sc3 !== 4'd5) begin
         n_err++; $display("FAIL lu3mw_count: got %0d want 5", sc3);
      end
   endtask

   task automatic test_saturate_and_reset_mid_stall;
      do_reset;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); set_idle; mem_req_mem = 1'b1;
      end
      @(negedge clk); set_idle; #1;
      n_cmp++;
      if (sc3 !== 4'd15) begin
         n_err++; $display("FAIL sat_perf4: got %0d want 15", sc3);
      end
      n_cmp++;
      if (sc1 !== 16'd20) begin
         n_err++; $display("FAIL count_perf16: got %0d want 20", sc1);
      end
      @(negedge clk); set_hz; #1;
      n_cmp++;
      if (ctl3 !== 5'b00100) begin
         n_err++; $display("FAIL mid_enter: got %b want 00100", ctl3);
      end
      @(negedge clk); set_idle; reset = 1'b1; #1;
      n_cmp++;
      if (ctl3 !== 5'b11000) begin
         n_err++; $display("FAIL mid_reset_force: got %b want 11000", ctl3);
      end
      @(negedge clk); reset = 1'b0; #1;
      n_cmp++;
      if (ctl3 !== 5'b11000 || sc3 !== 4'd0) begin
         n_err++; $display("FAIL mid_reset_run: got %b sc=%0d want 11000 sc=0", ctl3, sc3);
      end
   endtask

   task automatic test_back_to_back;
      do_reset;
      @(negedge clk); set_hz; #1;
      n_cmp++;
      if (ctl1 !== 5'b00100) begin
         n_err++; $display("FAIL b2b_first: got %b want 00100", ctl1);
      end
      @(negedge clk); set_idle; mem_read_ex = 1'b1; rt_ex = 5'd7; rt_id = 5'd7; uses_rt_id = 1'b1; #1;
      n_cmp++;
      if (ctl1 !== 5'b00100) begin
         n_err++; $display("FAIL b2b_second: got %b want 00100", ctl1);
      end
      @(negedge clk); set_idle; #1;
      n_cmp++;
      if (ctl1 !== 5'b11000 || sc1 !== 16'd2) begin
         n_err++; $display("FAIL b2b_resume: got %b sc=%0d want 11000 sc=2", ctl1, sc1);
      end
   endtask

   initial begin
      reset = 1'b1;
      set_idle;
      test_reset;
      test_load_use_1;
      test_no_hazard;
      test_load_use_2;
      test_mem_wait_flush;
      test_lu3_with_mem_wait;
      test_saturate_and_reset_mid_stall;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
